matrix_result_streamer: RTL and testbench
=========================================

# matrix_result_streamer

Downstream output stage of the matrix multiplier datapath. It captures the 16-bit result elements produced by the MAC/final-mux path, indexed by element position, into one of two ping-pong banks. It then streams each completed frame out in index order over a valid/ready interface with first/last markers. Because of the double buffering, the next multiplication can fill one bank while the previous frame drains from the other.

## Interface
- DATA_W, 16, result element width
- NUM_RES, 9, elements per frame (3x3 result matrix); must be 2..16
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  result element present this cycle
- in_idx  in  4  element index, 0..NUM_RES-1
- in_data  in  DATA_W  element value
- in_last  in  1  qualified by in_valid; this element closes the frame
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- out_data  out  DATA_W  streamed element; 0 when out_valid=0
- out_first  out  1  out_valid and element 0 of frame
- out_last  out  1  out_valid and element NUM_RES-1
- busy  out  1  either bank full or draining
- overflow_err  out  1  sticky: write dropped because target bank full
- incomplete_err  out  1  sticky: frame closed with missing indices, or in_idx >= NUM_RES
- frame_cnt  out  8  frames fully drained, wraps 255->0

## Operation
- Each bank holds NUM_RES x DATA_W data, a NUM_RES-bit written mask, and a full flag.
- The write pointer wbank and the read pointer rbank are each 1 bit.
- Write, on in_valid with bank[wbank] not full:
  - store in_data at in_idx and set the mask bit.
  - A repeated index overwrites the earlier value.
  - in_idx >= NUM_RES: data is dropped and incomplete_err is set. in_last still applies.
- in_last with in_valid, target bank not full:
  - set full on bank[wbank] and toggle wbank.
  - If the mask is incomplete, including the element stored this cycle, set incomplete_err. Missing elements read as 0.
- Write with in_valid while bank[wbank] is full: data and in_last are ignored, overflow_err is set, and wbank does not change.
- Read FSM:
  - IDLE: if bank[rbank].full, go to DRAIN with cnt=0.
  - DRAIN: out_valid=1 and out_data=bank[rbank][cnt].
    - On out_valid and out_ready: cnt increments.
    - At cnt=NUM_RES-1 the element is accepted and the frame is released:
      - bank[rbank] data, mask and full are cleared.
      - rbank toggles and frame_cnt increments.
      - If the other bank is already full, stay in DRAIN with cnt=0 (back-to-back, no bubble). Otherwise go to IDLE.
- out_data, out_first and out_last hold stable while out_valid=1 and out_ready=0.
- Sticky errors are cleared only by reset.

## Timing
- Reset state:
  - all outputs 0
  - wbank=rbank=0, FSM IDLE, cnt=0
  - all banks zeroed and not full
  - frame_cnt=0
- Reset mid-frame or mid-drain discards all buffered data immediately; there is no partial output after reset.
- Latency: in_last sampled at edge E0 sets full at E0. FSM enters DRAIN at E1, so out_valid is high in the cycle after E1 (2 clocks from in_last).
- Throughput: 1 element/cycle with out_ready held high; a frame takes NUM_RES cycles.
- Simultaneous release and in_last into the other bank: both take effect in the same edge.
- Simultaneous release of bank B and a write targeting bank B: full is evaluated on the pre-edge value, so the write is dropped and overflow_err is set.
- busy is registered-state derived: (bank0.full | bank1.full).

## Structure
- Package matrix_stream_pkg holds:
  - DATA_W and NUM_RES defaults
  - the read FSM state encoding (IDLE, DRAIN)
  - frame_cnt width
- Sub-module result_bank, instanced twice, contains:
  - storage, written mask, full flag
  - write port (we, idx, data, set_full)
  - combinational read port (idx)
  - single-cycle clear
  - complete output (mask all ones)
- The top holds the pointers, read FSM, counters and error logic.

## Test plan
- Single frame: write idx 0..8 with data 0x0100+idx, in_last on idx 8, out_ready=1.
  - Required: out_valid 2 clocks later.
  - Required: 9 beats 0x0100..0x0108, first on beat 0, last on beat 8.
  - Required: frame_cnt=1, busy=0 afterward.
- Backpressure: same frame, with out_ready toggled 1,0,0,1 repeating.
  - Required: each beat is held stable while stalled and no beat is lost or duplicated.
- Ping-pong: two frames written back-to-back (A=0x0A00+idx, B=0x0B00+idx) with out_ready=0, then out_ready=1.
  - Required: 18 contiguous beats, A then B, with no bubble between frames; frame_cnt=2.
- Overflow: with both banks full and undrained, write a third frame.
  - Required: overflow_err=1.
  - Required: drained frames remain A then B, with no third-frame data in them.
- Incomplete/bad index: frame omitting idx 4 and containing one write with idx 12.
  - Required: incomplete_err=1, beat 4 = 0x0000, other beats correct.
- Reset mid-drain: assert reset after beat 3.
  - Required: out_valid=0 immediately and all flags and frame_cnt at 0.
  - Required: a new frame after reset streams correctly from idx 0.

Source files
------------

// File: rtl/matrix_result_streamer_pkg.sv
// matrix_stream_pkg: shared defaults and types
// for the matrix result output stage.
package matrix_stream_pkg;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_RES = 9;
  localparam int FCNT_W      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;
endpackage

// File: rtl/matrix_result_streamer_bank.sv
// result_bank: one ping-pong frame buffer with
// written mask, full flag and single-cycle clear.
module result_bank
  import matrix_stream_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_RES = DEF_NUM_RES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        idx,
  input  logic [DATA_W-1:0] data,
  input  logic              set_full,
  input  logic              clr,
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              complete
);
  logic [NUM_RES-1:0][DATA_W-1:0] mem;
  logic [NUM_RES-1:0]             mask;
  logic [NUM_RES-1:0]             wbit;
  logic                           in_rng;
  logic                           rd_rng;

  assign in_rng = {1'b0, idx} < 5'(NUM_RES);
  assign rd_rng = {1'b0, rd_idx} < 5'(NUM_RES);

  // one-hot of the element stored at this edge
  always_comb begin
    wbit = '0;
    if (we && in_rng) wbit[idx] = 1'b1;
  end

  // complete counts the element being stored now
  assign complete = &(mask | wbit);
  assign rd_data  = rd_rng ? mem[rd_idx] : '0;

  // storage, mask and full; clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '0;
      mask <= '0;
      full <= 1'b0;
    end else if (clr) begin
      mem  <= '0;
      mask <= '0;
      full <= 1'b0;
    end else begin
      if (we && in_rng) mem[idx] <= data;
      mask <= mask | wbit;
      if (set_full) full <= 1'b1;
    end
  end
endmodule

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: double-buffered capture
// of result elements, streamed out in index order.
module matrix_result_streamer
  import matrix_stream_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_RES = DEF_NUM_RES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              overflow_err,
  output logic              incomplete_err,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam logic [3:0] LAST = 4'(NUM_RES - 1);

  rd_state_t              state;
  logic                   wbank;
  logic                   rbank;
  logic [3:0]             cnt;
  logic [1:0]             b_we;
  logic [1:0]             b_set;
  logic [1:0]             b_clr;
  logic [1:0]             b_full;
  logic [1:0]             b_cmp;
  logic [1:0][DATA_W-1:0] b_rd;
  logic                   wr_full;
  logic                   wr_en;
  logic                   bad_idx;
  logic                   rel;

  assign wr_full = b_full[wbank];
  assign wr_en   = in_valid & ~wr_full;
  assign bad_idx = {1'b0, in_idx} >= 5'(NUM_RES);
  assign rel     = (state == DRAIN) & out_ready
                 & (cnt == LAST);

  // steer write, close and release to the banks
  always_comb begin
    b_we         = '0;
    b_set        = '0;
    b_clr        = '0;
    b_we[wbank]  = wr_en;
    b_set[wbank] = wr_en & in_last;
    b_clr[rbank] = rel;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    result_bank #(
      .DATA_W  (DATA_W),
      .NUM_RES (NUM_RES)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .we       (b_we[g]),
      .idx      (in_idx),
      .data     (in_data),
      .set_full (b_set[g]),
      .clr      (b_clr[g]),
      .rd_idx   (cnt),
      .rd_data  (b_rd[g]),
      .full     (b_full[g]),
      .complete (b_cmp[g])
    );
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? b_rd[rbank] : '0;
  assign out_first = out_valid & (cnt == 4'd0);
  assign out_last  = out_valid & (cnt == LAST);
  assign busy      = |b_full;

  // write pointer and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank          <= 1'b0;
      overflow_err   <= 1'b0;
      incomplete_err <= 1'b0;
    end else begin
      if (in_valid & wr_full) overflow_err <= 1'b1;
      if (wr_en & (bad_idx | (in_last & ~b_cmp[wbank])))
        incomplete_err <= 1'b1;
      if (wr_en & in_last) wbank <= ~wbank;
    end
  end

  // read FSM: drain full banks, chain back-to-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rbank     <= 1'b0;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (b_full[rbank]) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              rbank     <= ~rbank;
              frame_cnt <= frame_cnt + FCNT_W'(1);
              state     <= b_full[~rbank] ? DRAIN : IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: directed frames checked
// against a frame-queue model every cycle.
module tb_matrix_result_streamer;
  import matrix_stream_pkg::*;

  localparam int W = DEF_DATA_W;
  localparam int N = DEF_NUM_RES;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    logic [W-1:0] d;
    logic         f;
    logic         l;
    int           c;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   in_idx = '0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_first;
  logic         out_last;
  logic         busy;
  logic         overflow_err;
  logic         incomplete_err;
  logic [7:0]   frame_cnt;

  matrix_result_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_idx         (in_idx),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_first      (out_first),
    .out_last       (out_last),
    .busy           (busy),
    .overflow_err   (overflow_err),
    .incomplete_err (incomplete_err),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: queue of closed frames awaiting drain
  frame_t       mq[$];
  frame_t       cur = '0;
  logic [N-1:0] cmask = '0;
  bit           m_drain = 0;
  int           m_pos = 0;
  logic [7:0]   m_fcnt = '0;
  bit           m_ovf = 0;
  bit           m_inc = 0;

  beat_t        got[$];
  bit           bp = 0;
  bit [3:0]     pat = 4'b1001;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int pre;
    pre = mq.size();
    if (m_drain) begin
      if (out_ready) begin
        if (m_pos == N - 1) begin
          void'(mq.pop_front());
          m_fcnt++;
          m_pos = 0;
          m_drain = (mq.size() > 0);
        end else begin
          m_pos++;
        end
      end
    end else if (pre > 0) begin
      m_drain = 1;
      m_pos = 0;
    end
    if (in_valid) begin
      if (pre == 2) begin
        m_ovf = 1;
      end else begin
        if (int'(in_idx) >= N) m_inc = 1;
        else begin
          cur[in_idx] = in_data;
          cmask[in_idx] = 1'b1;
        end
        if (in_last) begin
          if (cmask != '1) m_inc = 1;
          mq.push_back(cur);
          cur = '0;
          cmask = '0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      cur = '0;
      cmask = '0;
      m_drain = 0;
      m_pos = 0;
      m_fcnt = '0;
      m_ovf = 0;
      m_inc = 0;
    end else begin
      model_step();
    end
  end

  // per-cycle compare, hold check and beat capture
  initial begin
    logic         p_v;
    logic         p_r;
    logic [W+2:0] p_vec;
    logic [W-1:0] e_d;
    p_v = 0;
    p_r = 0;
    p_vec = '0;
    forever begin
      @(negedge clk);
      cyc++;
      e_d = m_drain ? mq[0][m_pos] : '0;
      chk("out_valid", 32'(out_valid), 32'(m_drain));
      chk("out_data", 32'(out_data), 32'(e_d));
      chk("out_first", 32'(out_first),
          32'(m_drain && m_pos == 0));
      chk("out_last", 32'(out_last),
          32'(m_drain && m_pos == N - 1));
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      chk("overflow_err", 32'(overflow_err),
          32'(m_ovf));
      chk("incomplete_err", 32'(incomplete_err),
          32'(m_inc));
      if (p_v && !p_r && !reset)
        chk("hold", 32'({out_valid, out_first,
                         out_last, out_data}),
            32'(p_vec));
      if (out_valid && out_ready)
        got.push_back('{out_data, out_first,
                        out_last, cyc});
      p_v = out_valid && !reset;
      p_r = out_ready;
      p_vec = {out_valid, out_first, out_last, out_data};
    end
  end

  // 1,0,0,1 backpressure pattern when enabled
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = pat[k];
        k = (k + 1) % 4;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic wr(input int idx,
                    input logic [W-1:0] d,
                    input bit last);
    in_valid = 1'b1;
    in_idx = 4'(idx);
    in_data = d;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wr_frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++)
      wr(i, base + W'(i), i == N - 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy || out_valid) && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(busy | out_valid), 0);
  endtask

  task automatic chk_beats(input string nm,
                           input logic [W-1:0] base,
                           input int off);
    for (int k = 0; k < N; k++) begin
      if (off + k < got.size()) begin
        chk({nm, "_data"}, 32'(got[off+k].d),
            32'(base + W'(k)));
        chk({nm, "_first"}, 32'(got[off+k].f),
            32'(k == 0));
        chk({nm, "_last"}, 32'(got[off+k].l),
            32'(k == N - 1));
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_errs", 32'({overflow_err, incomplete_err}), 0);
    reset = 1'b0;
    out_ready = 1'b1;

    got.delete();
    wr_frame(16'h0100);
    chk("lat_e0", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_e1", 32'(out_valid), 1);
    chk("lat_first", 32'(out_first), 1);
    wait_idle(50);
    chk("single_n", got.size(), 9);
    chk_beats("single", 16'h0100, 0);
    chk("single_fcnt", 32'(frame_cnt), 1);
    chk("single_busy", 32'(busy), 0);

    got.delete();
    bp = 1;
    wr_frame(16'h0100);
    wait_idle(100);
    bp = 0;
    out_ready = 1'b1;
    chk("bp_n", got.size(), 9);
    chk_beats("bp", 16'h0100, 0);
    chk("bp_fcnt", 32'(frame_cnt), 2);

    got.delete();
    out_ready = 1'b0;
    wr_frame(16'h0A00);
    wr_frame(16'h0B00);
    chk("pp_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_idle(100);
    chk("pp_n", got.size(), 18);
    chk_beats("ppA", 16'h0A00, 0);
    chk_beats("ppB", 16'h0B00, 9);
    if (got.size() == 18)
      chk("pp_contig", got[17].c - got[0].c, 17);
    chk("pp_fcnt", 32'(frame_cnt), 4);

    got.delete();
    out_ready = 1'b0;
    wr_frame(16'h0A00);
    wr_frame(16'h0B00);
    chk("ov_before", 32'(overflow_err), 0);
    wr_frame(16'h0C00);
    chk("ov_set", 32'(overflow_err), 1);
    out_ready = 1'b1;
    wait_idle(100);
    chk("ov_n", got.size(), 18);
    chk_beats("ovA", 16'h0A00, 0);
    chk_beats("ovB", 16'h0B00, 9);
    chk("ov_fcnt", 32'(frame_cnt), 6);

    got.delete();
    chk("inc_before", 32'(incomplete_err), 0);
    for (int i = 0; i < N; i++) begin
      if (i == 2) wr(12, 16'hDEAD, 0);
      if (i != 4) wr(i, 16'h0E00 + W'(i), i == N - 1);
    end
    chk("inc_set", 32'(incomplete_err), 1);
    wait_idle(50);
    chk("inc_n", got.size(), 9);
    for (int k = 0; k < N; k++)
      if (k < got.size())
        chk("inc_data", 32'(got[k].d),
            (k == 4) ? 0 : 32'h0E00 + k);
    chk("inc_fcnt", 32'(frame_cnt), 7);

    got.delete();
    wr_frame(16'h0D00);
    for (int n = 0; n < 50 && got.size() < 4; n++) begin
      @(posedge clk);
      #1;
    end
    chk("rd_beats", got.size(), 4);
    reset = 1'b1;
    #1;
    chk("rd_valid", 32'(out_valid), 0);
    chk("rd_data", 32'(out_data), 0);
    chk("rd_busy", 32'(busy), 0);
    chk("rd_fcnt", 32'(frame_cnt), 0);
    chk("rd_errs", 32'({overflow_err, incomplete_err}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    got.delete();
    wr_frame(16'h0F00);
    wait_idle(50);
    chk("post_n", got.size(), 9);
    chk_beats("post", 16'h0F00, 0);
    chk("post_fcnt", 32'(frame_cnt), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
